mor1kx_cfgrs_spr_arbiter: RTL

- Shares the read-only group-0 configuration SPR file between two requesters: the CPU SPR access path (port 0) and the debug unit (port 1).
- Arbitrates between them and decodes the SPR address against the eleven configuration buses.
- Returns registered read data with a one-cycle ack pulse, and flags illegal writes and unmapped addresses.
- Sits between the configuration SPR block and the CPU control stage / debug interface.

---
 rtl/mor1kx_cfgrs_spr_arbiter_pkg.sv | 19 +
 rtl/mor1kx_cfgrs_spr_arbiter_if.sv | 16 +
 rtl/mor1kx_cfgrs_spr_decode.sv | 24 ++
 rtl/mor1kx_cfgrs_spr_arbiter.sv | 91 +++++++++
 4 files changed

// File: rtl/mor1kx_cfgrs_spr_arbiter_pkg.sv
// mor1kx_cfgrs_spr_arbiter_pkg: group-0 SPR indices, port ids and FSM states shared by the arbiter
package mor1kx_cfgrs_spr_arbiter_pkg;
  localparam int NUM_CFG = 11;
  localparam logic [3:0] OR1K_SPR_VR_INDEX       = 4'd0;
  localparam logic [3:0] OR1K_SPR_UPR_INDEX      = 4'd1;
  localparam logic [3:0] OR1K_SPR_CPUCFGR_INDEX  = 4'd2;
  localparam logic [3:0] OR1K_SPR_DMMUCFGR_INDEX = 4'd3;
  localparam logic [3:0] OR1K_SPR_IMMUCFGR_INDEX = 4'd4;
  localparam logic [3:0] OR1K_SPR_DCCFGR_INDEX   = 4'd5;
  localparam logic [3:0] OR1K_SPR_ICCFGR_INDEX   = 4'd6;
  localparam logic [3:0] OR1K_SPR_DCFGR_INDEX    = 4'd7;
  localparam logic [3:0] OR1K_SPR_PCCFGR_INDEX   = 4'd8;
  localparam logic [3:0] OR1K_SPR_VR2_INDEX      = 4'd9;
  localparam logic [3:0] OR1K_SPR_AVR_INDEX      = 4'd10;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DU  = 1'b1;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOOKUP = 2'd1, ST_ACK = 2'd2} state_t;
  typedef logic [NUM_CFG-1:0][31:0] cfg_t;
endpackage

// File: rtl/mor1kx_cfgrs_spr_arbiter_if.sv
// mor1kx_cfgrs_spr_arbiter_if: CPU and debug-unit request/response signals of the SPR arbiter
interface mor1kx_cfgrs_spr_arbiter_if;
  logic        cpu_req_i, cpu_we_i, cpu_abort_i, cpu_ack_o, cpu_err_o;
  logic [15:0] cpu_addr_i;
  logic        du_req_i, du_we_i, du_ack_o, du_err_o;
  logic [15:0] du_addr_i;
  logic [31:0] rdata_o;
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_abort_i, du_req_i, du_we_i, du_addr_i,
    input  cpu_ack_o, cpu_err_o, du_ack_o, du_err_o, rdata_o
  );
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_abort_i, du_req_i, du_we_i, du_addr_i,
    output cpu_ack_o, cpu_err_o, du_ack_o, du_err_o, rdata_o
  );
endinterface

// File: rtl/mor1kx_cfgrs_spr_decode.sv
// mor1kx_cfgrs_spr_decode: maps a group-0 SPR address onto the configuration registers
module mor1kx_cfgrs_spr_decode
  import mor1kx_cfgrs_spr_arbiter_pkg::*;
#(
  parameter logic [7:0] OPTION_PIPELINE_ID = 8'h00
) (
  input  cfg_t        i_cfg,
  input  logic [15:0] i_addr,
  input  logic        i_we,
  output logic [31:0] o_data,
  output logic        o_err
);
  logic [15:0][31:0] w_tab;
  logic              w_hit;
  always_comb begin
    w_tab = '0;
    w_tab[NUM_CFG-1:0] = i_cfg;
    w_tab[OR1K_SPR_VR2_INDEX][7:0] = i_cfg[OR1K_SPR_VR2_INDEX][7:0] | OPTION_PIPELINE_ID;
  end
  assign w_hit  = i_addr[15:11] == 5'd0 && i_addr[10:0] < 11'(NUM_CFG);
  // the whole file is read-only, so any write is an error as well
  assign o_err  = i_we || !w_hit;
  assign o_data = o_err ? '0 : w_tab[i_addr[3:0]];
endmodule

// File: rtl/mor1kx_cfgrs_spr_arbiter.sv
// mor1kx_cfgrs_spr_arbiter: shares the group-0 configuration SPRs between the CPU and the debug unit
module mor1kx_cfgrs_spr_arbiter
  import mor1kx_cfgrs_spr_arbiter_pkg::*;
#(
  parameter string      OPTION_ARB_POLICY  = "RR",
  parameter logic [7:0] OPTION_PIPELINE_ID = 8'h00
) (
  input logic                        clk,
  input logic                        rst,
  mor1kx_cfgrs_spr_arbiter_if.slave  bus,
  input logic [31:0]                 spr_vr_i,
  input logic [31:0]                 spr_vr2_i,
  input logic [31:0]                 spr_upr_i,
  input logic [31:0]                 spr_cpucfgr_i,
  input logic [31:0]                 spr_dmmucfgr_i,
  input logic [31:0]                 spr_immucfgr_i,
  input logic [31:0]                 spr_dccfgr_i,
  input logic [31:0]                 spr_iccfgr_i,
  input logic [31:0]                 spr_dcfgr_i,
  input logic [31:0]                 spr_pccfgr_i,
  input logic [31:0]                 spr_avr_i
);
  localparam bit CPU_FIRST = OPTION_ARB_POLICY == "CPU_FIRST";
  state_t      r_state, w_next;
  logic        r_last_grant, r_port, r_we, r_abort, r_err;
  logic [15:0] r_addr;
  logic [31:0] r_rdata, w_data;
  logic        w_any, w_grant, w_abort, w_err;
  cfg_t        w_cfg;
  always_comb begin
    w_cfg = '0;
    w_cfg[OR1K_SPR_VR_INDEX]       = spr_vr_i;
    w_cfg[OR1K_SPR_UPR_INDEX]      = spr_upr_i;
    w_cfg[OR1K_SPR_CPUCFGR_INDEX]  = spr_cpucfgr_i;
    w_cfg[OR1K_SPR_DMMUCFGR_INDEX] = spr_dmmucfgr_i;
    w_cfg[OR1K_SPR_IMMUCFGR_INDEX] = spr_immucfgr_i;
    w_cfg[OR1K_SPR_DCCFGR_INDEX]   = spr_dccfgr_i;
    w_cfg[OR1K_SPR_ICCFGR_INDEX]   = spr_iccfgr_i;
    w_cfg[OR1K_SPR_DCFGR_INDEX]    = spr_dcfgr_i;
    w_cfg[OR1K_SPR_PCCFGR_INDEX]   = spr_pccfgr_i;
    w_cfg[OR1K_SPR_VR2_INDEX]      = spr_vr2_i;
    w_cfg[OR1K_SPR_AVR_INDEX]      = spr_avr_i;
  end
  mor1kx_cfgrs_spr_decode #(.OPTION_PIPELINE_ID(OPTION_PIPELINE_ID)) u_decode (
    .i_cfg  (w_cfg),
    .i_addr (r_addr),
    .i_we   (r_we),
    .o_data (w_data),
    .o_err  (w_err)
  );
  assign w_any   = bus.cpu_req_i || bus.du_req_i;
  assign w_grant = (bus.cpu_req_i && bus.du_req_i) ? (CPU_FIRST ? PORT_CPU : ~r_last_grant)
                                                   : (bus.cpu_req_i ? PORT_CPU : PORT_DU);
  // a flush seen either in the grant cycle or in LOOKUP cancels a CPU access
  assign w_abort = r_port == PORT_CPU && (bus.cpu_abort_i || r_abort);
  always_comb begin
    w_next = ST_IDLE;
    w_next = (r_state == ST_IDLE) ? (w_any ? ST_LOOKUP : ST_IDLE) :
             (r_state == ST_LOOKUP && !w_abort) ? ST_ACK : ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PORT_DU;
      r_port       <= PORT_CPU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_abort      <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_any) begin
        r_port       <= w_grant;
        r_last_grant <= w_grant;
        r_we         <= w_grant ? bus.du_we_i : bus.cpu_we_i;
        r_addr       <= w_grant ? bus.du_addr_i : bus.cpu_addr_i;
        r_abort      <= !w_grant && bus.cpu_abort_i;
      end
      if (r_state == ST_LOOKUP && !w_abort) begin
        r_rdata <= w_data;
        r_err   <= w_err;
      end
    end
  end
  assign bus.cpu_ack_o = r_state == ST_ACK && r_port == PORT_CPU;
  assign bus.du_ack_o  = r_state == ST_ACK && r_port == PORT_DU;
  assign bus.cpu_err_o = bus.cpu_ack_o && r_err;
  assign bus.du_err_o  = bus.du_ack_o && r_err;
  assign bus.rdata_o   = r_rdata;
endmodule
